// File: rtl/uart_cmd_if.sv
// uart_cmd_if: receiver/transmitter handshake and register-write bus of the command controller.
interface uart_cmd_if;
    logic       rx_done;
    logic [7:0] uart_rxd;
    logic       tx_busy;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       reg_wr_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] frame_err_cnt;
    modport master (
        output rx_done, uart_rxd, tx_busy,
        input  tx_req, tx_data, reg_wr_en, reg_addr, reg_wdata, frame_err_cnt
    );
    modport slave (
        input  rx_done, uart_rxd, tx_busy,
        output tx_req, tx_data, reg_wr_en, reg_addr, reg_wdata, frame_err_cnt
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses header/addr/data/checksum frames from the UART receiver,
// issues register writes and answers every complete frame with ACK or NAK.
module uart_cmd_ctrl #(
    parameter int         CLOCK_FREQ = 50_000_000,
    parameter int         TIMEOUT_US = 1000,
    parameter logic [7:0] HDR_BYTE   = 8'h55,
    parameter logic [7:0] ACK_BYTE   = 8'hAA,
    parameter logic [7:0] NAK_BYTE   = 8'hEE
) (
    input logic       sys_clk,
    input logic       sys_rst_n,
    uart_cmd_if.slave bus
);
    localparam logic [31:0] TO_MAX = 32'(CLOCK_FREQ / 1_000_000 * TIMEOUT_US);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CHK, EXEC, REPLY} state_t;
    state_t      state;
    logic        rx_done_d;
    logic [31:0] to_cnt;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic        rx_evt;
    logic        in_frame;
    logic [7:0]  err_next;
    assign rx_evt   = bus.rx_done & ~rx_done_d;
    assign in_frame = (state == ADDR) || (state == DATA) || (state == CHK);
    assign err_next = bus.frame_err_cnt + {7'd0, bus.frame_err_cnt != 8'hFF};
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state             <= IDLE;
            rx_done_d         <= 1'b0;
            to_cnt            <= '0;
            addr_q            <= '0;
            data_q            <= '0;
            bus.tx_req        <= 1'b0;
            bus.tx_data       <= '0;
            bus.reg_wr_en     <= 1'b0;
            bus.reg_addr      <= '0;
            bus.reg_wdata     <= '0;
            bus.frame_err_cnt <= '0;
        end else begin
            rx_done_d     <= bus.rx_done;
            bus.tx_req    <= 1'b0;
            bus.reg_wr_en <= 1'b0;
            to_cnt        <= (rx_evt || !in_frame) ? '0 : to_cnt + 32'd1;
            // a byte arriving in the same cycle as expiry keeps the frame alive
            if (in_frame && !rx_evt && to_cnt >= TO_MAX) begin
                bus.frame_err_cnt <= err_next;
                state             <= IDLE;
            end else begin
                case (state)
                    IDLE: if (rx_evt && bus.uart_rxd == HDR_BYTE) state <= ADDR;
                    ADDR: if (rx_evt) begin
                        addr_q <= bus.uart_rxd;
                        state  <= DATA;
                    end
                    DATA: if (rx_evt) begin
                        data_q <= bus.uart_rxd;
                        state  <= CHK;
                    end
                    CHK: if (rx_evt) begin
                        if (bus.uart_rxd == 8'(addr_q + data_q)) begin
                            state <= EXEC;
                        end else begin
                            bus.tx_data       <= NAK_BYTE;
                            bus.frame_err_cnt <= err_next;
                            state             <= REPLY;
                        end
                    end
                    EXEC: begin
                        bus.reg_wr_en <= 1'b1;
                        bus.reg_addr  <= addr_q;
                        bus.reg_wdata <= data_q;
                        bus.tx_data   <= ACK_BYTE;
                        state         <= REPLY;
                    end
                    REPLY: if (!bus.tx_busy) begin
                        bus.tx_req <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frames against hand-computed register writes, replies and error counts.
module tb_uart_cmd_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    uart_cmd_if bus ();
    uart_cmd_ctrl #(
        .CLOCK_FREQ(50_000_000), .TIMEOUT_US(10),
        .HDR_BYTE(8'h55), .ACK_BYTE(8'hAA), .NAK_BYTE(8'hEE)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
    );
    int cyc = 0, wr_cnt = 0, req_cnt = 0, wr_cyc = 0, rise_cyc = 0;
    int tests = 0, fails = 0;
    int w0, r0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.reg_wr_en === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            wr_cyc = cyc;
        end
        if (bus.tx_req === 1'b1) req_cnt = req_cnt + 1;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input int hold = 1);
        @(posedge clk);
        #1;
        bus.uart_rxd = b;
        bus.rx_done  = 1'b1;
        rise_cyc     = cyc;
        repeat (hold) @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask
    task automatic send_frame(input logic [7:0] h, a, d, c, input int hold = 1);
        send_byte(h, hold);
        send_byte(a, hold);
        send_byte(d, hold);
        send_byte(c, hold);
        repeat (6) @(posedge clk);
        #1;
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_tx_req"}, 32'(bus.tx_req), 0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        check({tag, "_wr_en"}, 32'(bus.reg_wr_en), 0);
        check({tag, "_addr"}, 32'(bus.reg_addr), 0);
        check({tag, "_wdata"}, 32'(bus.reg_wdata), 0);
        check({tag, "_err"}, 32'(bus.frame_err_cnt), 0);
    endtask
    initial begin
        bus.rx_done  = 1'b0;
        bus.uart_rxd = 8'h00;
        bus.tx_busy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        // valid frame
        w0 = wr_cnt; r0 = req_cnt;
        send_frame(8'h55, 8'h10, 8'h22, 8'h32);
        check("ok_wr", 32'(wr_cnt), 32'(w0 + 1));
        check("ok_lat", 32'(wr_cyc - rise_cyc), 2);
        check("ok_addr", 32'(bus.reg_addr), 32'h10);
        check("ok_wdata", 32'(bus.reg_wdata), 32'h22);
        check("ok_req", 32'(req_cnt), 32'(r0 + 1));
        check("ok_tx", 32'(bus.tx_data), 32'hAA);
        check("ok_err", 32'(bus.frame_err_cnt), 0);
        // checksum failure
        w0 = wr_cnt; r0 = req_cnt;
        send_frame(8'h55, 8'h10, 8'h22, 8'h33);
        check("bad_wr", 32'(wr_cnt), 32'(w0));
        check("bad_req", 32'(req_cnt), 32'(r0 + 1));
        check("bad_tx", 32'(bus.tx_data), 32'hEE);
        check("bad_err", 32'(bus.frame_err_cnt), 1);
        check("bad_addr", 32'(bus.reg_addr), 32'h10);
        check("bad_wdata", 32'(bus.reg_wdata), 32'h22);
        // truncated frame, timeout after 500 idle cycles
        w0 = wr_cnt; r0 = req_cnt;
        send_byte(8'h55);
        send_byte(8'hF0);
        repeat (700) @(posedge clk);
        #1;
        check("to_req", 32'(req_cnt), 32'(r0));
        check("to_err", 32'(bus.frame_err_cnt), 2);
        check("to_wr", 32'(wr_cnt), 32'(w0));
        send_frame(8'h55, 8'h01, 8'h02, 8'h03);
        check("to_next_wr", 32'(wr_cnt), 32'(w0 + 1));
        check("to_next_addr", 32'(bus.reg_addr), 32'h01);
        check("to_next_wdata", 32'(bus.reg_wdata), 32'h02);
        check("to_next_tx", 32'(bus.tx_data), 32'hAA);
        // long rx_done level, checksum wraps
        w0 = wr_cnt; r0 = req_cnt;
        send_frame(8'h55, 8'hFF, 8'h02, 8'h01, 25);
        check("hold_wr", 32'(wr_cnt), 32'(w0 + 1));
        check("hold_addr", 32'(bus.reg_addr), 32'hFF);
        check("hold_wdata", 32'(bus.reg_wdata), 32'h02);
        check("hold_req", 32'(req_cnt), 32'(r0 + 1));
        // transmitter busy; byte during REPLY is dropped
        bus.tx_busy = 1'b1;
        w0 = wr_cnt; r0 = req_cnt;
        send_frame(8'h55, 8'h10, 8'h22, 8'h32);
        check("busy_wr", 32'(wr_cnt), 32'(w0 + 1));
        send_byte(8'h55);
        repeat (85) @(posedge clk);
        #1;
        check("busy_noreq", 32'(req_cnt), 32'(r0));
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 20 && req_cnt == r0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("busy_req", 32'(req_cnt), 32'(r0 + 1));
        check("busy_tx", 32'(bus.tx_data), 32'hAA);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (6) @(posedge clk);
        #1;
        check("busy_drop", 32'(wr_cnt), 32'(w0 + 1));
        // leading garbage, header value as payload
        w0 = wr_cnt;
        send_byte(8'h00);
        send_byte(8'h13);
        send_frame(8'h55, 8'h55, 8'h00, 8'h55);
        check("hdr_wr", 32'(wr_cnt), 32'(w0 + 1));
        check("hdr_addr", 32'(bus.reg_addr), 32'h55);
        check("hdr_wdata", 32'(bus.reg_wdata), 32'h00);
        // error counter saturation
        w0 = wr_cnt; r0 = req_cnt;
        for (int i = 0; i < 260; i++) send_frame(8'h55, 8'h01, 8'h01, 8'h00);
        check("sat_err", 32'(bus.frame_err_cnt), 32'hFF);
        check("sat_req", 32'(req_cnt), 32'(r0 + 260));
        check("sat_wr", 32'(wr_cnt), 32'(w0));
        check("sat_addr", 32'(bus.reg_addr), 32'h55);
        check("sat_tx", 32'(bus.tx_data), 32'hEE);
        // reset mid-frame
        w0 = wr_cnt; r0 = req_cnt;
        send_byte(8'h55);
        send_byte(8'h10);
        rst_n = 1'b0;
        #2;
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h22);
        send_byte(8'h32);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_wr", 32'(wr_cnt), 32'(w0));
        check("midrst_req", 32'(req_cnt), 32'(r0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer placed after the UART byte receiver. It turns the raw received byte stream into 4-byte write frames (header, address, data, checksum) and validates each frame. Valid frames drive a one-cycle register-write strobe. Every complete frame is answered with an ACK or NAK byte through a busy/request handshake to the UART transmitter. An inter-byte timeout resynchronises the parser when a frame is truncated.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
TIMEOUT_US, 1000, maximum idle gap between bytes inside a frame, in microseconds
HDR_BYTE, 8'h55, frame header value
ACK_BYTE, 8'hAA, reply byte for a valid frame
NAK_BYTE, 8'hEE, reply byte for a checksum failure

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
rx_done  input  1  byte-received flag from the UART receiver; may stay high for several cycles
uart_rxd  input  8  received byte; valid while rx_done is high
tx_busy  input  1  UART transmitter busy
tx_req  output  1  one-cycle pulse that starts transmission of tx_data
tx_data  output  8  reply byte; held stable from tx_req until the next reply
reg_wr_en  output  1  one-cycle register-write strobe
reg_addr  output  8  register address; held after the strobe
reg_wdata  output  8  register write data; held after the strobe
frame_err_cnt  output  8  saturating count of checksum failures plus timeouts

Behaviour:
- Asynchronous reset: every output is 0, state is IDLE, and the timeout counter is 0.
- Byte event: rx_evt = rx_done & ~rx_done_d, where rx_done_d is rx_done registered once.
  - The byte is sampled from uart_rxd in the rx_evt cycle.
  - A level that stays high for several cycles counts as exactly one byte.
- Timeout limit: TO_MAX = CLOCK_FREQ/1_000_000*TIMEOUT_US.
  - The counter is 32 bits wide and clears on every rx_evt.
  - It counts only in ADDR, DATA and CHK.
- Checksum: (addr + data) mod 256, 8-bit wrap. The header is not included.
- States and transitions:
  - IDLE: on rx_evt with byte == HDR_BYTE, go to ADDR. Any other byte is discarded and the block stays in IDLE.
  - ADDR: on rx_evt, latch the address and go to DATA.
  - DATA: on rx_evt, latch the data and go to CHK.
  - CHK: on rx_evt, compare the byte with the checksum.
    - Match: go to EXEC.
    - Mismatch: set tx_data = NAK_BYTE, increment frame_err_cnt, go to REPLY.
  - Timeout: in ADDR, DATA or CHK, when the counter reaches TO_MAX with no rx_evt:
    - increment frame_err_cnt and go to IDLE;
    - send no reply and discard the partial frame.
  - EXEC (1 cycle): drive reg_wr_en=1 with reg_addr and reg_wdata updated in the same cycle, set tx_data = ACK_BYTE, go to REPLY.
  - REPLY: wait until tx_busy == 0, then pulse tx_req for one cycle and go to IDLE.
- Write latency: reg_wr_en asserts 2 cycles after the rx_evt of the checksum byte.
- Reply latency: tx_req asserts no earlier than the cycle after entry to REPLY.
- Bytes arriving in EXEC or REPLY are dropped and are not counted as errors. The parser resynchronises on the next HDR_BYTE seen in IDLE.
- A header value received in ADDR, DATA or CHK is treated as ordinary payload. There is no restart mid-frame.
- Simultaneous rx_evt and timeout in the same cycle: rx_evt wins and the counter clears.
- frame_err_cnt saturates at 8'hFF and never wraps.
- reg_addr and reg_wdata change only in EXEC. A failed or timed-out frame never modifies them.
- Reset asserted mid-frame or mid-REPLY aborts the frame immediately. No tx_req and no reg_wr_en are produced afterwards.

Test Plan:
- Bytes 55,10,22,32 with tx_busy=0 -> one reg_wr_en pulse with addr 8'h10, data 8'h22; then one tx_req with tx_data 8'hAA; frame_err_cnt stays 0.
- Bytes 55,10,22,33 -> no reg_wr_en; tx_req with tx_data 8'hEE; frame_err_cnt=1; reg_addr and reg_wdata unchanged.
- Bytes 55,F0 then silence longer than TO_MAX (set TIMEOUT_US=10) -> back to IDLE with no tx_req; frame_err_cnt=1. Next frame 55,01,02,03 -> write addr 01, data 02, then ACK.
- rx_done held high 25 cycles per byte for frame 55,FF,02,01 (checksum wraps to 01) -> exactly one write, addr FF, data 02, then ACK.
- Valid frame with tx_busy=1 for 100 cycles after the checksum byte -> tx_req asserts only after tx_busy falls. Extra byte 55 sent during the wait is dropped and does not start a new frame.
- Leading garbage 00,13 then frame 55,55,00,55 -> write addr 55, data 00. Then 260 bad-checksum frames -> frame_err_cnt saturates at FF. Reset mid-frame -> all outputs 0 and no strobe.
